spi_master_v2: RTL
==================

# spi_master_v2

Parametrised second-generation SPI master for the epRISC I/O bus. It keeps the four-register memory-mapped interface on a shared tri-state data bus and adds several features:
- a single system clock with an internal programmable SCLK divider;
- all four CPOL/CPHA modes;
- MSB- or LSB-first shifting and a configurable word width;
- multiple decoded slave selects;
- a sticky completion flag that drives an interrupt.

## Interface
- DATA_W, 8: bits per transfer, 1..32.
- NUM_SS, 4: number of slave-select outputs, 1..16.
- DIV_W, 16: width of the SCLK divider register.
- iClk  in  1  system clock; all logic on rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iAddr  in  2  register select: 0 CTRL, 1 TXDATA, 2 RXDATA, 3 DIV.
- bData  inout  32  bus data; driven only when iEnable && !iWrite, else high-Z.
- iWrite  in  1  write strobe, qualified by iEnable.
- iEnable  in  1  chip select for this peripheral.
- iMISO  in  1  serial data in.
- oMOSI  out  1  serial data out.
- oSCLK  out  1  serial clock.
- oSS  out  NUM_SS  slave selects, active-low.
- oInt  out  1  interrupt, level, = CTRL.DONE && CTRL.IE.

## Operation
- CTRL bits:
  - [0] START/BUSY: write 1 starts a transfer; reads 1 while busy.
  - [1] CPOL.
  - [2] CPHA.
  - [3] LSBF.
  - [4] IE.
  - [5] DONE: sticky; write 1 to clear.
  - [6] SSHOLD.
  - [7] LOOP (see Configuration).
  - [11:8] SSIDX.
  - [12] OVR: sticky; write 1 to clear.
  - Other bits read 0.
- TXDATA: low DATA_W bits are used. RXDATA: read-only, zero-extended. DIV: low DIV_W bits; SCLK half-period = DIV+1 iClk cycles.
- Writes take effect on the iClk edge where iEnable && iWrite.
- START write while idle:
  - snapshot CPOL, CPHA, LSBF, SSIDX and DIV;
  - load the shift register from TXDATA;
  - enter SETUP.
- START write while busy is ignored.
- TXDATA write while busy is dropped and sets OVR.
- CTRL/DIV writes while busy update the registers but affect only the next transfer.
- FSM states:
  - IDLE -> SETUP on start.
  - SETUP (one half-period): SS asserted, first bit on MOSI, SCLK = CPOL.
  - SHIFT (2*DATA_W half-periods): SCLK toggles each half-period. CPHA=0 samples on the leading edge and shifts on the trailing edge; CPHA=1 shifts on the leading edge and samples on the trailing edge.
  - HOLD (one half-period): SCLK = CPOL.
  - DONE (one iClk): RXDATA updated, DONE set -> IDLE.
- Bit order: MSB-first shifts from bit DATA_W-1; LSBF shifts from bit 0. Received bits land in the mirror position.
- SS: oSS[SSIDX] is low from SETUP through HOLD. If SSHOLD=1 it stays low in IDLE until SSHOLD is cleared. SSIDX >= NUM_SS asserts no select.
- Idle outputs: oSCLK = CTRL.CPOL (live), oMOSI = 1.
- DONE set and software clear in the same cycle: set wins.

## Timing
- Reset values:
  - oSS all 1, oSCLK 0, oMOSI 1, oInt 0;
  - CTRL, TXDATA, RXDATA = 0;
  - DIV = 0;
  - FSM in IDLE.
- Reset asserted mid-transfer aborts immediately: SS deasserts, no RXDATA update, DONE not set.
- BUSY reads 1 on the cycle after the START write.
- Transfer length, from the START write edge to DONE=1, is (2*DATA_W+2)*(DIV+1)+1 iClk cycles. Example: DATA_W=8, DIV=0 gives 19.
- RXDATA and DONE update on the same edge. oInt follows one cycle later at most (combinational from registers).
- Read data is combinational from registers at the current iAddr.

## Configuration
- SPI_LOOPBACK_EN:
  - Defined: CTRL[7] is read/write. When it is set, the receive path samples oMOSI instead of iMISO, and iMISO is ignored.
  - Undefined: CTRL[7] reads 0, writes are ignored, and no loopback mux is synthesised.

## Structure
- Package spi_v2_pkg holds:
  - register address constants (CTRL/TXDATA/RXDATA/DIV);
  - CTRL bit-position constants;
  - FSM state encoding.
- Sub-module spi_v2_clkgen is a divider counter. It takes iClk, iRst, enable and the snapshot DIV. It emits a one-cycle half-period tick, plus lead/trail edge strobes based on an edge-parity bit.
- The top holds registers, the bus decode, the FSM, the shift register and the SS decode.

## Test plan
- Mode 0, DIV=0, DATA_W=8, TX=0xA5, MISO driven 0x3C: MOSI bits 1,0,1,0,0,1,0,1; RXDATA=0x3C; DONE after 19 cycles; oInt=1 with IE=1.
- All four CPOL/CPHA modes, DIV=3, TX=0x81: SCLK idle level = CPOL, half-period 4 cycles, sample edge per CPHA, RXDATA matches the slave model.
- LSBF=1, TX=0x01: first MOSI bit 1 then seven 0s. DATA_W=12 build, TX=0xABC: 12 SCLK pulses, RXDATA bits [31:12]=0.
- Boundaries:
  - START while busy: ignored, no second transfer.
  - TXDATA write while busy: OVR=1, shifted data unchanged.
  - SSIDX=5 with NUM_SS=4: oSS stays all 1.
  - SSHOLD=1: SS stays low between two back-to-back transfers.
- Async reset asserted mid-SHIFT (not clock-aligned): oSS all 1, oSCLK 0 immediately, RXDATA unchanged, DONE=0.
- With SPI_LOOPBACK_EN and LOOP=1, TX=0x5A: RXDATA=0x5A regardless of iMISO. Without the macro, CTRL[7] reads 0 after writing 1.

Source files
------------

// File: rtl/spi_v2_pkg.sv
// Shared register map, CTRL bit positions and FSM encoding for spi_master_v2.
package spi_v2_pkg;

   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrTxdata = 2'd1;
   localparam logic [1:0] AddrRxdata = 2'd2;
   localparam logic [1:0] AddrDiv    = 2'd3;

   localparam int unsigned CtrlStart  = 0;
   localparam int unsigned CtrlCpol   = 1;
   localparam int unsigned CtrlCpha   = 2;
   localparam int unsigned CtrlLsbf   = 3;
   localparam int unsigned CtrlIe     = 4;
   localparam int unsigned CtrlDone   = 5;
   localparam int unsigned CtrlSshold = 6;
   localparam int unsigned CtrlLoop   = 7;
   localparam int unsigned CtrlSsidx  = 8;
   localparam int unsigned CtrlOvr    = 12;
   localparam int unsigned SsidxW     = 4;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShift,
      StHold,
      StDone
   } spi_state_e;

endpackage

// File: rtl/spi_v2_clkgen.sv
// SCLK divider: one-cycle tick every iDiv+1 cycles while enabled, split into
// leading/trailing edge strobes by a parity bit that restarts with the enable.
module spi_v2_clkgen #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iEn,
   input  logic [DIV_W-1:0] iDiv,
   output logic             oTick,
   output logic             oLead,
   output logic             oTrail
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             par_q, par_d;

   always_comb begin
      oTick = iEn && (cnt_q == iDiv);
      cnt_d = cnt_q + DIV_W'(1);
      par_d = par_q;
      if (!iEn || oTick) begin
         cnt_d = '0;
      end
      if (!iEn) begin
         par_d = 1'b0;
      end else if (oTick) begin
         par_d = ~par_q;
      end
      // First tick after enable is a leading edge.
      oLead  = oTick && !par_q;
      oTrail = oTick && par_q;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cnt_q <= '0;
         par_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         par_q <= par_d;
      end
   end

endmodule

// File: rtl/spi_master_v2.sv
// SPI master with bus-mapped CTRL/TXDATA/RXDATA/DIV registers and decoded selects.
// Optional loopback of MOSI into the receive path when SPI_LOOPBACK_EN is defined.
module spi_master_v2
   import spi_v2_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_SS = 4,
   parameter int unsigned DIV_W  = 16
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic [1:0]        iAddr,
   inout  logic [31:0]       bData,
   input  logic              iWrite,
   input  logic              iEnable,
   input  logic              iMISO,
   output logic              oMOSI,
   output logic              oSCLK,
   output logic [NUM_SS-1:0] oSS,
   output logic              oInt
);

   localparam int unsigned NumEdges = 2 * DATA_W;
   localparam int unsigned EdgeW    = $clog2(NumEdges + 1);

   spi_state_e state_q, state_d;

   logic              cpol_q, cpol_d, cpha_q, cpha_d, lsbf_q, lsbf_d, ie_q, ie_d;
   logic              done_q, done_d, sshold_q, sshold_d, ovr_q, ovr_d;
   logic [SsidxW-1:0] ssidx_q, ssidx_d;
   logic [DATA_W-1:0] txdata_q, txdata_d, rxdata_q, rxdata_d;
   logic [DIV_W-1:0]  div_q, div_d;

   logic              s_cpol_q, s_cpol_d, s_cpha_q, s_cpha_d, s_lsbf_q, s_lsbf_d;
   logic [SsidxW-1:0] s_ssidx_q, s_ssidx_d;
   logic [DIV_W-1:0]  s_div_q, s_div_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
   logic [EdgeW-1:0]  edge_cnt_q, edge_cnt_d;
   logic              tog_q, tog_d;

   logic [31:0] wdata, rdata;
   logic        wr_ctrl, wr_tx, wr_div, idle, in_xfer, start;
   logic        tick, lead, trail, do_edge, mosi_bit, rx_in, loop_bit;
   logic        unused_wdata;

   assign wdata        = bData;
   assign unused_wdata = ^wdata;
   assign bData        = (iEnable && !iWrite) ? rdata : 'z;

   assign wr_ctrl = iEnable && iWrite && (iAddr == AddrCtrl);
   assign wr_tx   = iEnable && iWrite && (iAddr == AddrTxdata);
   assign wr_div  = iEnable && iWrite && (iAddr == AddrDiv);
   assign idle    = (state_q == StIdle);
   assign in_xfer = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
   assign start   = wr_ctrl && wdata[CtrlStart] && idle;

   assign mosi_bit = s_lsbf_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];

`ifdef SPI_LOOPBACK_EN
   logic loop_q, loop_d;

   always_comb begin
      loop_d = loop_q;
      if (wr_ctrl) begin
         loop_d = wdata[CtrlLoop];
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         loop_q <= 1'b0;
      end else begin
         loop_q <= loop_d;
      end
   end

   assign loop_bit = loop_q;
   assign rx_in    = loop_q ? mosi_bit : iMISO;
`else
   assign loop_bit = 1'b0;
   assign rx_in    = iMISO;
`endif

   spi_v2_clkgen #(
      .DIV_W(DIV_W)
   ) u_clkgen (
      .iClk  (iClk),
      .iRst  (iRst),
      .iEn   (in_xfer),
      .iDiv  (s_div_q),
      .oTick (tick),
      .oLead (lead),
      .oTrail(trail)
   );

   // Software-visible registers.
   always_comb begin
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      lsbf_d   = lsbf_q;
      ie_d     = ie_q;
      done_d   = done_q;
      sshold_d = sshold_q;
      ssidx_d  = ssidx_q;
      ovr_d    = ovr_q;
      txdata_d = txdata_q;
      rxdata_d = rxdata_q;
      div_d    = div_q;
      if (wr_ctrl) begin
         cpol_d   = wdata[CtrlCpol];
         cpha_d   = wdata[CtrlCpha];
         lsbf_d   = wdata[CtrlLsbf];
         ie_d     = wdata[CtrlIe];
         sshold_d = wdata[CtrlSshold];
         ssidx_d  = wdata[CtrlSsidx +: SsidxW];
         if (wdata[CtrlDone]) begin
            done_d = 1'b0;
         end
         if (wdata[CtrlOvr]) begin
            ovr_d = 1'b0;
         end
      end
      if (wr_tx) begin
         if (idle) begin
            txdata_d = wdata[DATA_W-1:0];
         end else begin
            ovr_d = 1'b1;
         end
      end
      if (wr_div) begin
         div_d = wdata[DIV_W-1:0];
      end
      // Completion overrides a same-cycle software clear.
      if (state_q == StDone) begin
         done_d   = 1'b1;
         rxdata_d = rx_sr_q;
      end
   end

   // Transfer FSM and shift datapath.
   always_comb begin
      state_d    = state_q;
      s_cpol_d   = s_cpol_q;
      s_cpha_d   = s_cpha_q;
      s_lsbf_d   = s_lsbf_q;
      s_ssidx_d  = s_ssidx_q;
      s_div_d    = s_div_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      edge_cnt_d = edge_cnt_q;
      tog_d      = tog_q;
      do_edge    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StSetup;
               s_cpol_d   = wdata[CtrlCpol];
               s_cpha_d   = wdata[CtrlCpha];
               s_lsbf_d   = wdata[CtrlLsbf];
               s_ssidx_d  = wdata[CtrlSsidx +: SsidxW];
               s_div_d    = div_q;
               tx_sr_d    = txdata_q;
               rx_sr_d    = '0;
               edge_cnt_d = '0;
               tog_d      = 1'b0;
            end
         end
         StSetup: begin
            if (tick) begin
               state_d = StShift;
               do_edge = 1'b1;
            end
         end
         StShift: begin
            if (tick) begin
               if (edge_cnt_q == EdgeW'(NumEdges)) begin
                  state_d = StHold;
               end else begin
                  do_edge = 1'b1;
               end
            end
         end
         StHold: begin
            if (tick) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (do_edge) begin
         edge_cnt_d = edge_cnt_q + EdgeW'(1);
         tog_d      = ~tog_q;
         if (s_cpha_q ? trail : lead) begin
            if (s_lsbf_q) begin
               rx_sr_d = (rx_sr_q >> 1) | (DATA_W'(rx_in) << (DATA_W - 1));
            end else begin
               rx_sr_d = (rx_sr_q << 1) | DATA_W'(rx_in);
            end
         end else if (!(s_cpha_q && state_q == StSetup)) begin
            // CPHA=1 keeps the first bit, already presented during SETUP, on the first edge.
            tx_sr_d = s_lsbf_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
         end
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         lsbf_q   <= 1'b0;
         ie_q     <= 1'b0;
         done_q   <= 1'b0;
         sshold_q <= 1'b0;
         ssidx_q  <= '0;
         ovr_q    <= 1'b0;
         txdata_q <= '0;
         rxdata_q <= '0;
         div_q    <= '0;
      end else begin
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         lsbf_q   <= lsbf_d;
         ie_q     <= ie_d;
         done_q   <= done_d;
         sshold_q <= sshold_d;
         ssidx_q  <= ssidx_d;
         ovr_q    <= ovr_d;
         txdata_q <= txdata_d;
         rxdata_q <= rxdata_d;
         div_q    <= div_d;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q    <= StIdle;
         s_cpol_q   <= 1'b0;
         s_cpha_q   <= 1'b0;
         s_lsbf_q   <= 1'b0;
         s_ssidx_q  <= '0;
         s_div_q    <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         edge_cnt_q <= '0;
         tog_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_cpol_q   <= s_cpol_d;
         s_cpha_q   <= s_cpha_d;
         s_lsbf_q   <= s_lsbf_d;
         s_ssidx_q  <= s_ssidx_d;
         s_div_q    <= s_div_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         edge_cnt_q <= edge_cnt_d;
         tog_q      <= tog_d;
      end
   end

   // Outputs and read mux are combinational from registers.
   always_comb begin
      oMOSI = in_xfer ? mosi_bit : 1'b1;
      oSCLK = in_xfer ? (s_cpol_q ^ tog_q) : cpol_q;
      oInt  = done_q && ie_q;
      for (int i = 0; i < NUM_SS; i++) begin
         oSS[i] = !((in_xfer || sshold_q) && (s_ssidx_q == SsidxW'(i)));
      end
   end

   always_comb begin
      rdata = '0;
      case (iAddr)
         AddrCtrl: rdata = {19'b0, ovr_q, ssidx_q, loop_bit, sshold_q, done_q, ie_q,
                            lsbf_q, cpha_q, cpol_q, !idle};
         AddrTxdata: rdata = 32'(txdata_q);
         AddrRxdata: rdata = 32'(rxdata_q);
         AddrDiv:    rdata = 32'(div_q);
         default:    rdata = '0;
      endcase
   end

endmodule
